// File: rtl/button_debounce.sv
// rtl/button_debounce.sv - Synchronized, debounced push-button with press/release/long-press pulses (optional feature macro: LONG_PRESS_EN)
module button_debounce #(
    parameter int DEBOUNCE_CYCLES   = 16,
    parameter int LONG_PRESS_CYCLES = 1000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic btn_i,
    output logic btn_level_o,
    output logic btn_press_o,
    output logic btn_release_o,
    output logic long_press_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Reject out-of-range parameters at elaboration time.
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535 ||
        LONG_PRESS_CYCLES < 2 || LONG_PRESS_CYCLES > 16777215) begin : g_bad_param
        $error("button_debounce: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_RELEASED        = 2'd0,
        ST_PRESS_PENDING   = 2'd1,
        ST_PRESSED         = 2'd2,
        ST_RELEASE_PENDING = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             btn_s;

    // Two-flop synchronizer; btn_s is the only form of the button used downstream.
    always_comb begin
        sync1_d = btn_i;
        sync2_d = sync1_q;
    end

    assign btn_s = sync2_q;

    // Debounce FSM: a level change is accepted once the pending counter has
    // seen DEBOUNCE_CYCLES and the input is still at the new level.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            ST_RELEASED: begin
                if (btn_s) begin
                    state_d = ST_PRESS_PENDING;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            ST_PRESS_PENDING: begin
                if (!btn_s) begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_DONE) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    press_d = 1'b1;
                end else begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                end
            end
            ST_PRESSED: begin
                if (!btn_s) begin
                    state_d = ST_RELEASE_PENDING;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            ST_RELEASE_PENDING: begin
                if (btn_s) begin
                    // Glitch while held: back to PRESSED silently.
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_DONE) begin
                    state_d   = ST_RELEASED;
                    cnt_d     = '0;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                end else begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_RELEASED;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    // State, counter, synchronizer and output registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_RELEASED;
            cnt_q     <= '0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_level_o   = level_q;
    assign btn_press_o   = press_q;
    assign btn_release_o = release_q;

`ifdef LONG_PRESS_EN
    localparam logic [23:0] HOLD_DONE = 24'(LONG_PRESS_CYCLES);

    logic [23:0] hold_q, hold_d;
    logic        long_q, long_d;

    // Hold counter: restarts on each accepted press, advances while held
    // (including release glitches) and saturates at the threshold so the
    // long-press pulse fires only once per press. A cycle that accepts a
    // release never advances it, keeping release and long-press exclusive.
    always_comb begin
        hold_d = hold_q;
        long_d = 1'b0;
        if (state_q == ST_PRESS_PENDING && state_d == ST_PRESSED) begin
            hold_d = '0;
        end else if ((state_q == ST_PRESSED || state_q == ST_RELEASE_PENDING) &&
                     state_d != ST_RELEASED && hold_q != HOLD_DONE) begin
            hold_d = hold_q + 24'd1;
            long_d = ((hold_q + 24'd1) == HOLD_DONE);
        end
    end

    // Hold counter and long-press pulse registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            hold_q <= hold_d;
            long_q <= long_d;
        end
    end

    assign long_press_o = long_q;
`else
    assign long_press_o = 1'b0;
`endif

endmodule
